// File: rtl/sum3_out_fifo.sv
// sum3_out_fifo: output buffer behind the sum-every-3 stage.
// Captures each strobed sum and re-presents it on a valid/ready interface.
// The buffer is a small circular FIFO with first-word fall-through, an
// occupancy count and a sticky overflow flag.
// Optional feature: define SUM3_OUT_FIFO_PEAK_EN to add o_peak, which holds
// the largest value accepted since reset.
module sum3_out_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_dval,
    input  logic [DW-1:0]          i,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [DW-1:0]          o,
    output logic [$clog2(DEPTH):0] o_cnt,
    output logic                   o_ovf
`ifdef SUM3_OUT_FIFO_PEAK_EN
    ,
    output logic [DW-1:0]          o_peak
`endif
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop;
    logic          push;

    // Handshake decode: a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        o_valid = 1'b0;
        o       = '0;
        pop     = 1'b0;
        push    = 1'b0;
        o_valid = (o_cnt != '0);
        o       = o_valid ? mem[rptr] : '0;
        pop     = o_valid & o_ready;
        push    = i_dval & ((o_cnt != FULL) | pop);
    end

    // Storage write. The data array has no reset; its contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= i;
        end
    end

    // Pointers, occupancy and sticky overflow. Pointers wrap because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            o_cnt <= '0;
            o_ovf <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   o_cnt <= o_cnt + ONE;
                2'b01:   o_cnt <= o_cnt - ONE;
                default: o_cnt <= o_cnt;
            endcase
            if (i_dval & ~push) begin
                o_ovf <= 1'b1;
            end
        end
    end

`ifdef SUM3_OUT_FIFO_PEAK_EN
    // Running unsigned maximum of accepted pushes. Dropped pushes never reach it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_peak <= '0;
        end else if (push && (i > o_peak)) begin
            o_peak <= i;
        end
    end
`endif

endmodule
